// File: rtl/aes_dec_pkg.sv
// Shared widths, counter sizes and FSM encoding for the AES-128 decrypt block feeder.
package aes_dec_pkg;
  localparam int WORD_W = 32;
  localparam int BLOCK_W = 128;
  localparam int WCNT_W = 2;
  localparam int SCNT_W = 4;
  localparam logic [WCNT_W-1:0] WCNT_LAST = '1;

  typedef enum logic [1:0] {FILL, SETTLE, HOLD} state_e;
endpackage

// File: rtl/aes_word_packer.sv
// Four-slot 32-bit indexed write register forming one 128-bit block.
// MSB_FIRST places word index 0 in the most significant slot.
module aes_word_packer
  import aes_dec_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [WCNT_W-1:0]  idx_i,
  input  logic [WORD_W-1:0]  word_i,
  output logic [BLOCK_W-1:0] blk_o
);
  localparam int NWORDS = BLOCK_W / WORD_W;

  logic [BLOCK_W-1:0] blk_q;
  logic [WCNT_W-1:0]  slot;

  assign slot = MSB_FIRST ? (WCNT_W'(NWORDS - 1) - idx_i) : idx_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (slot == WCNT_W'(i)) blk_q[i*WORD_W +: WORD_W] <= word_i;
      end
    end
  end

  assign blk_o = blk_q;
endmodule

// File: rtl/aes_dec_block_feeder.sv
// Packs key/ciphertext words for the combinational AES-128 decryptor, waits SETTLE_CYCLES,
// then captures the plaintext and offers it downstream over valid/ready.
module aes_dec_block_feeder
  import aes_dec_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_is_key,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] key_out,
  output logic [BLOCK_W-1:0] ct_out,
  input  logic [BLOCK_W-1:0] pt_in,
  output logic [BLOCK_W-1:0] pt_out,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic               key_valid,
  output logic               err_pulse
);
  state_e             state_q;
  logic [WCNT_W-1:0]  key_wcnt_q;
  logic [WCNT_W-1:0]  data_wcnt_q;
  logic [SCNT_W-1:0]  settle_cnt_q;
  logic               key_valid_q;
  logic               pt_valid_q;
  logic [BLOCK_W-1:0] pt_q;
  logic               err_q;

  logic key_acc;
  logic ct_acc;
  logic ct_drop;
  logic last_ct;

  // Key words are refused in HOLD; the 4th ciphertext word waits until the result drains.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      FILL:    in_ready = 1'b1;
      HOLD:    in_ready = !in_is_key && ((data_wcnt_q != WCNT_LAST) || pt_ready);
      default: in_ready = 1'b0;
    endcase
  end

  assign key_acc = in_valid && in_ready && in_is_key;
  assign ct_acc  = in_valid && in_ready && !in_is_key && key_valid_q;
  assign ct_drop = in_valid && in_ready && !in_is_key && !key_valid_q;
  assign last_ct = ct_acc && (data_wcnt_q == WCNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      key_wcnt_q   <= '0;
      data_wcnt_q  <= '0;
      settle_cnt_q <= '0;
      key_valid_q  <= 1'b0;
      pt_valid_q   <= 1'b0;
      pt_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= ct_drop || (key_acc && (data_wcnt_q != '0));

      if (key_acc) begin
        key_wcnt_q <= key_wcnt_q + 1'b1;
        if (key_wcnt_q == '0) key_valid_q <= 1'b0;
        if (key_wcnt_q == WCNT_LAST) key_valid_q <= 1'b1;
        if (data_wcnt_q != '0) data_wcnt_q <= '0;
      end
      if (ct_acc) data_wcnt_q <= data_wcnt_q + 1'b1;

      unique case (state_q)
        FILL: begin
          if (last_ct) begin
            state_q      <= SETTLE;
            settle_cnt_q <= SCNT_W'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (settle_cnt_q == '0) begin
            pt_q       <= pt_in;
            pt_valid_q <= 1'b1;
            state_q    <= HOLD;
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (pt_ready) begin
            pt_valid_q <= 1'b0;
            if (last_ct) begin
              state_q      <= SETTLE;
              settle_cnt_q <= SCNT_W'(SETTLE_CYCLES - 1);
            end else begin
              state_q <= FILL;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Key word 0 lands in the leftmost bits, matching big-endian [0:31] numbering.
  aes_word_packer #(.MSB_FIRST(1'b1)) u_key_pack (
    .clk    (clk),
    .rst    (rst),
    .we_i   (key_acc),
    .idx_i  (key_wcnt_q),
    .word_i (in_word),
    .blk_o  (key_out)
  );

  aes_word_packer #(.MSB_FIRST(1'b1)) u_ct_pack (
    .clk    (clk),
    .rst    (rst),
    .we_i   (ct_acc),
    .idx_i  (data_wcnt_q),
    .word_i (in_word),
    .blk_o  (ct_out)
  );

  assign pt_out    = pt_q;
  assign pt_valid  = pt_valid_q;
  assign key_valid = key_valid_q;
  assign err_pulse = err_q;
endmodule

// File: tb/tb_aes_dec_block_feeder.sv
// Bench for aes_dec_block_feeder: a behavioural AES-128 inverse cipher stands in for the
// decryptor, and a word-level model predicts plaintexts and error pulses.
module tb_aes_dec_block_feeder;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_word = '0;
  logic         in_is_key = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] key_out, ct_out, pt_in, pt_out;
  logic         pt_valid;
  logic         pt_ready = 1'b0;
  logic         key_valid, err_pulse;

  int n_checks = 0;
  int n_fail = 0;
  int got_err = 0;
  int exp_err = 0;
  int rd_idx = 0;
  logic [127:0] got_pt[$];
  logic [127:0] exp_pt[$];

  logic [31:0] mk[4];
  int          mkcnt;
  bit          mkvalid;
  logic [31:0] mblk[$];

  aes_dec_block_feeder #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_is_key(in_is_key), .in_valid(in_valid),
    .in_ready(in_ready), .key_out(key_out), .ct_out(ct_out), .pt_in(pt_in), .pt_out(pt_out),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .key_valid(key_valid), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, b;
    logic [7:0] e;
    r = 8'h01;
    b = x;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w[44];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s[16];
    logic [7:0]   u[16];
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    st = ct ^ {w[40], w[41], w[42], w[43]};
    for (int r = 9; r >= 0; r--) begin
      for (int k = 0; k < 16; k++) s[k] = st[127-8*k -: 8];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          u[rr+4*c] = isbox(s[rr + 4*((c - rr + 4) % 4)]);
      for (int k = 0; k < 16; k++) st[127-8*k -: 8] = u[k];
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (r != 0) begin
        for (int k = 0; k < 16; k++) s[k] = st[127-8*k -: 8];
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          u[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          u[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          u[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          u[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        for (int k = 0; k < 16; k++) st[127-8*k -: 8] = u[k];
      end
    end
    return st;
  endfunction

  always_comb pt_in = aes_dec(key_out, ct_out);

  // Observe results and error pulses on the falling edge, clear of the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (err_pulse) got_err++;
        if (pt_valid && pt_ready) got_pt.push_back(pt_out);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    mkcnt = 0;
    mkvalid = 0;
    for (int i = 0; i < 4; i++) mk[i] = '0;
    mblk.delete();
    while (exp_pt.size() > got_pt.size()) void'(exp_pt.pop_back());
  endtask

  task automatic model_word(input logic [31:0] w, input bit is_key);
    if (is_key) begin
      if (mkcnt == 0) mkvalid = 0;
      if (mblk.size() != 0) begin
        mblk.delete();
        exp_err++;
      end
      mk[mkcnt] = w;
      if (mkcnt == 3) mkvalid = 1;
      mkcnt = (mkcnt + 1) % 4;
    end else if (!mkvalid) begin
      exp_err++;
    end else begin
      mblk.push_back(w);
      if (mblk.size() == 4) begin
        exp_pt.push_back(aes_dec({mk[0], mk[1], mk[2], mk[3]}, {mblk[0], mblk[1], mblk[2], mblk[3]}));
        mblk.delete();
      end
    end
  endtask

  // Presents one word and returns just after the edge on which it was taken.
  task automatic send_word(input logic [31:0] w, input bit is_key);
    bit ok;
    ok = 0;
    in_word = w;
    in_is_key = is_key;
    in_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_word: in_ready stayed %b, want 1 within 40 cycles", in_ready);
    end else begin
      model_word(w, is_key);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_random_key();
    for (int i = 0; i < 4; i++) send_word($urandom(), 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 7;
    if (key_out !== '0) begin n_fail++; $display("FAIL reset_key_out: got %h want 0", key_out); end
    if (ct_out !== '0) begin n_fail++; $display("FAIL reset_ct_out: got %h want 0", ct_out); end
    if (pt_out !== '0) begin n_fail++; $display("FAIL reset_pt_out: got %h want 0", pt_out); end
    if (pt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pt_valid: got %b want 0", pt_valid); end
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fips();
    logic [31:0] kw[4];
    logic [31:0] cw[4];
    kw = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    cw = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    pt_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(kw[i], 1'b1);
    @(negedge clk);
    n_checks++;
    if (key_valid !== 1'b1) begin n_fail++; $display("FAIL fips_key_valid: got %b want 1", key_valid); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_word(cw[i], 1'b0);
    for (int k = 0; k <= S; k++) begin
      @(negedge clk);
      n_checks += 3;
      if (pt_valid !== (k == S)) begin n_fail++; $display("FAIL fips_pt_valid_timing: cycle %0d got %b want %b", k, pt_valid, k == S); end
      if (ct_out !== {cw[0], cw[1], cw[2], cw[3]}) begin n_fail++; $display("FAIL fips_ct_out: got %h", ct_out); end
      if (key_out !== {kw[0], kw[1], kw[2], kw[3]}) begin n_fail++; $display("FAIL fips_key_out: got %h", key_out); end
      if (k < S) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fips_settle_in_ready: cycle %0d got %b want 0", k, in_ready); end
        @(posedge clk);
      end
    end
    n_checks++;
    if (pt_out !== 128'h00112233445566778899aabbccddeeff) begin
      n_fail++; $display("FAIL fips_pt_out: got %h want 00112233445566778899aabbccddeeff", pt_out);
    end
    @(posedge clk); #1;
    pt_ready = 1'b1;
    @(posedge clk); #1;
    pt_ready = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (pt_valid !== 1'b0) begin n_fail++; $display("FAIL fips_pt_drain: got %b want 0", pt_valid); end
    if (got_pt.size() != exp_pt.size()) begin n_fail++; $display("FAIL fips_result_count: got %0d want %0d", got_pt.size(), exp_pt.size()); end
    while (rd_idx < got_pt.size() && rd_idx < exp_pt.size()) begin
      n_checks++;
      if (got_pt[rd_idx] !== exp_pt[rd_idx]) begin n_fail++; $display("FAIL fips_result: got %h want %h", got_pt[rd_idx], exp_pt[rd_idx]); end
      rd_idx++;
    end
  endtask

  task automatic test_no_key();
    bit seen;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    pt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word($urandom(), 1'b0);
      @(negedge clk);
      n_checks += 2;
      if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL nokey_err_pulse: word %0d got %b want 1", i, err_pulse); end
      if (dut.data_wcnt_q !== 2'd0) begin n_fail++; $display("FAIL nokey_data_wcnt: got %0d want 0", dut.data_wcnt_q); end
      @(negedge clk);
      n_checks++;
      if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL nokey_err_width: got %b want 0", err_pulse); end
      @(posedge clk); #1;
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (pt_valid) seen = 1;
    end
    n_checks += 2;
    if (seen) begin n_fail++; $display("FAIL nokey_pt_valid: got 1 want 0"); end
    if (got_err != exp_err) begin n_fail++; $display("FAIL nokey_err_count: got %0d want %0d", got_err, exp_err); end
    @(posedge clk); #1;
    pt_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] pt_hold;
    logic [31:0]  b[4];
    pt_ready = 1'b0;
    load_random_key();
    for (int i = 0; i < 4; i++) send_word($urandom(), 1'b0);
    for (int n = 0; n < 20 && !pt_valid; n++) @(negedge clk);
    n_checks += 2;
    if (pt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", pt_valid); end
    if (pt_out !== exp_pt[exp_pt.size()-1]) begin n_fail++; $display("FAIL bp_first_pt: got %h want %h", pt_out, exp_pt[exp_pt.size()-1]); end
    pt_hold = pt_out;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) b[i] = $urandom();
    for (int i = 0; i < 3; i++) send_word(b[i], 1'b0);
    in_word = b[3];
    in_is_key = 1'b0;
    in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_checks += 3;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_in_ready: got %b want 0", in_ready); end
      if (pt_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_pt_valid: got %b want 1", pt_valid); end
      if (pt_out !== pt_hold) begin n_fail++; $display("FAIL bp_pt_stable: got %h want %h", pt_out, pt_hold); end
      @(posedge clk); #1;
    end
    pt_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    else model_word(b[3], 1'b0);
    @(posedge clk); #1;
    pt_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_settle_in_ready: got %b want 0", in_ready); end
    if (pt_valid !== 1'b0) begin n_fail++; $display("FAIL bp_settle_pt_valid: got %b want 0", pt_valid); end
    for (int n = 0; n < 20 && !pt_valid; n++) @(negedge clk);
    @(posedge clk); #1;
    pt_ready = 1'b1;
    @(posedge clk); #1;
    pt_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 2;
    if (got_pt.size() != exp_pt.size()) begin n_fail++; $display("FAIL bp_result_count: got %0d want %0d", got_pt.size(), exp_pt.size()); end
    if (got_err != exp_err) begin n_fail++; $display("FAIL bp_err_count: got %0d want %0d", got_err, exp_err); end
    while (rd_idx < got_pt.size() && rd_idx < exp_pt.size()) begin
      n_checks++;
      if (got_pt[rd_idx] !== exp_pt[rd_idx]) begin n_fail++; $display("FAIL bp_result: got %h want %h", got_pt[rd_idx], exp_pt[rd_idx]); end
      rd_idx++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_key_interrupt();
    pt_ready = 1'b1;
    send_word($urandom(), 1'b0);
    send_word($urandom(), 1'b0);
    send_word($urandom(), 1'b1);
    @(negedge clk);
    n_checks += 3;
    if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL kint_err_pulse: got %b want 1", err_pulse); end
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL kint_key_valid: got %b want 0", key_valid); end
    if (dut.data_wcnt_q !== 2'd0) begin n_fail++; $display("FAIL kint_data_wcnt: got %0d want 0", dut.data_wcnt_q); end
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) send_word($urandom(), 1'b1);
    @(negedge clk);
    n_checks++;
    if (key_valid !== 1'b1) begin n_fail++; $display("FAIL kint_reload_key_valid: got %b want 1", key_valid); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_word($urandom(), 1'b0);
    for (int n = 0; n < 40 && got_pt.size() < exp_pt.size(); n++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks += 2;
    if (got_pt.size() != exp_pt.size()) begin n_fail++; $display("FAIL kint_result_count: got %0d want %0d", got_pt.size(), exp_pt.size()); end
    if (got_err != exp_err) begin n_fail++; $display("FAIL kint_err_count: got %0d want %0d", got_err, exp_err); end
    while (rd_idx < got_pt.size() && rd_idx < exp_pt.size()) begin
      n_checks++;
      if (got_pt[rd_idx] !== exp_pt[rd_idx]) begin n_fail++; $display("FAIL kint_result: got %h want %h", got_pt[rd_idx], exp_pt[rd_idx]); end
      rd_idx++;
    end
    @(posedge clk); #1;
    pt_ready = 1'b0;
  endtask

  task automatic test_reset_settle();
    bit seen;
    pt_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word($urandom(), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks += 7;
    if (pt_valid !== 1'b0) begin n_fail++; $display("FAIL rstset_pt_valid: got %b want 0", pt_valid); end
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rstset_key_valid: got %b want 0", key_valid); end
    if (key_out !== '0) begin n_fail++; $display("FAIL rstset_key_out: got %h want 0", key_out); end
    if (ct_out !== '0) begin n_fail++; $display("FAIL rstset_ct_out: got %h want 0", ct_out); end
    if (pt_out !== '0) begin n_fail++; $display("FAIL rstset_pt_out: got %h want 0", pt_out); end
    if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL rstset_err_pulse: got %b want 0", err_pulse); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstset_in_ready: got %b want 1", in_ready); end
    pt_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (pt_valid) seen = 1;
    end
    n_checks += 2;
    if (seen) begin n_fail++; $display("FAIL rstset_stale_delivery: got pt_valid 1 want 0"); end
    if (got_pt.size() != rd_idx) begin n_fail++; $display("FAIL rstset_result_count: got %0d want %0d", got_pt.size(), rd_idx); end
    @(posedge clk); #1;
    send_word($urandom(), 1'b0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (got_err != exp_err) begin n_fail++; $display("FAIL rstset_err_count: got %0d want %0d", got_err, exp_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int err0;
    int base;
    load_random_key();
    pt_ready = 1'b1;
    err0 = got_err;
    base = exp_pt.size();
    for (int i = 0; i < 12; i++) send_word($urandom(), 1'b0);
    for (int n = 0; n < 60 && got_pt.size() < exp_pt.size(); n++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks += 3;
    if (exp_pt.size() != base + 3) begin n_fail++; $display("FAIL b2b_model_blocks: got %0d want %0d", exp_pt.size() - base, 3); end
    if (got_pt.size() != exp_pt.size()) begin n_fail++; $display("FAIL b2b_result_count: got %0d want %0d", got_pt.size(), exp_pt.size()); end
    if (got_err != err0) begin n_fail++; $display("FAIL b2b_err_pulse: got %0d pulses want 0", got_err - err0); end
    while (rd_idx < got_pt.size() && rd_idx < exp_pt.size()) begin
      n_checks++;
      if (got_pt[rd_idx] !== exp_pt[rd_idx]) begin n_fail++; $display("FAIL b2b_result: got %h want %h", got_pt[rd_idx], exp_pt[rd_idx]); end
      rd_idx++;
    end
    pt_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fips();
    test_no_key();
    test_backpressure();
    test_key_interrupt();
    test_reset_settle();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
